decode_stage: RTL
=================

# decode_stage

Instruction decode stage for the five-stage RV32I pipeline. Sits between fetch and the execute stage: registers each fetched instruction, splits it into opcode/func3/func7/register numbers, builds the sign-extended immediate, and presents them to execute for one cycle. Also owns pipeline control for the front end: load-use stall detection (hazard) and branch/jump squash (flush) after execute asserts pcWriteEnable.

## Interface
- FLUSH_CYCLES, 2, cycles of flush/bubble issued after a taken PC write (younger instructions squashed)
- clk  in  1  pipeline clock; all state updates on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clk
- instr  in  32  fetched instruction word
- instrPC  in  32  address of instr
- instrValid  in  1  instr/instrPC carry a real instruction
- pcWriteEnable  in  1  execute has redirected the PC this cycle (taken branch, jal, jalr)
- stall  out  1  combinational; fetch must hold instr/instrPC/instrValid stable next cycle
- hazard  out  1  registered; high while a load-use bubble is in execute
- flush  out  1  registered; high while a squash bubble is in execute
- PC  out  32  address of issued instruction
- opcode  out  7  instr[6:0]; 7'b0000000 = bubble
- func3  out  3  instr[14:12]
- func7  out  7  instr[31:25]
- regNum0  out  5  rs1, or 0 if format has no rs1
- regNum1  out  5  rs2, or 0 if format has no rs2
- regWriteNum  out  5  rd, or 0 if format writes no register
- imm  out  32  decoded immediate

## Operation
- State machine: RUN, STALL, FLUSH. Reset -> RUN.
- Bubble: all decode outputs (PC, opcode, func3, func7, regNum0/1, regWriteNum, imm) zero.
- Field rules per opcode:
  - 0110011 R: rs1, rs2, rd; imm 0.
  - 0010011 I-ALU, 0000011 load, 1100111 jalr: rs1, rd; imm = sext(instr[31:20]) (shift immediates left raw so imm[10] = instr[30]).
  - 0100011 S: rs1, rs2, rd 0; imm = sext({instr[31:25], instr[11:7]}).
  - 1100011 B: rs1, rs2, rd 0; imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 0110111 lui, 0010111 auipc: rd; imm = {instr[31:12], 12'b0}.
  - 1101111 jal: rd; imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - any other opcode, or instrValid=0: issue bubble.
- Load-use detect (combinational, RUN only): issued opcode == 0000011, issued regWriteNum != 0, and regWriteNum equals a used rs1/rs2 of the incoming valid instr -> stall=1.
- RUN: pcWriteEnable -> load bubble, flush=1, counter = FLUSH_CYCLES-1, go FLUSH (if FLUSH_CYCLES==1, go RUN). Else stall -> load bubble, hazard=1, go STALL. Else decode incoming instr.
- STALL (one cycle): stall=0; decode the held instr; hazard=0; go RUN. pcWriteEnable here follows RUN's flush rule.
- FLUSH: each cycle load bubble, flush=1; counter decrements; at 0 go RUN, flush=0 on the following issue. Incoming instr ignored; pcWriteEnable restarts counter at FLUSH_CYCLES-1.
- Priority: reset > pcWriteEnable > load-use stall > normal decode.

## Timing
- Latency 1: instr sampled at edge N appears on outputs after edge N, held one cycle.
- stall depends only on registered outputs and current instr inputs; no path from pcWriteEnable to stall.
- hazard and flush change only on clock edges; never both high.
- Reset: all outputs 0 (opcode bubble), hazard=0, flush=0, stall=0, state RUN, counter 0. Reset mid-STALL or mid-FLUSH aborts immediately.
- Back-to-back loads: each dependent consumer gets exactly one bubble.
- rd=x0 never triggers stall.

## Test plan
- Reset then instr=0x00500093 (addi x1,x0,5), valid: next cycle opcode=0010011, regNum0=0, regWriteNum=1, imm=5, PC=instrPC.
- lw x2,0(x1) then add x3,x2,x1: stall=1 one cycle, then bubble with hazard=1, then add issued with regNum0=2, regNum1=1; hazard back to 0.
- lw x0,0(x1) then add x3,x0,x1: no stall, no bubble.
- beq issued, pcWriteEnable=1 that cycle: next 2 cycles bubbles with flush=1, incoming instrs discarded, third cycle issues new-target instr with flush=0.
- Immediate check: instr 0xFE000EE3 (beq, imm -4) -> imm=0xFFFFFFFC; 0x123450B7 (lui) -> imm=0x12345000; 0x40505093 (srai x1,x0,5) -> imm[10]=1.
- pcWriteEnable and load-use stall same cycle: flush wins, hazard stays 0; reset asserted mid-FLUSH -> all outputs 0, flush=0 next cycle.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage with load-use stall and branch-squash control.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   instr, instrPC      fetched instruction and its address
//   instrValid          instr/instrPC hold a real instruction
//   pcWriteEnable       execute redirected the PC this cycle
//   stall               combinational; fetch holds its outputs next cycle
//   hazard, flush       registered; a load-use or squash bubble is in execute
//   PC .. imm           registered decode fields; all zero for a bubble
module decode_stage #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] instrPC,
    input  logic        instrValid,
    input  logic        pcWriteEnable,
    output logic        stall,
    output logic        hazard,
    output logic        flush,
    output logic [31:0] PC,
    output logic [6:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [4:0]  regNum0,
    output logic [4:0]  regNum1,
    output logic [4:0]  regWriteNum,
    output logic [31:0] imm
);
    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] STALL = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    logic [1:0]    state, next_state;
    logic [CW-1:0] cnt, next_cnt;
    logic [6:0]    op;
    logic          is_r, is_i, is_s, is_b, is_u, is_j, valid, dec;
    logic [4:0]    d_rs1, d_rs2, d_rd;
    logic [31:0]   d_imm;

    assign op   = instr[6:0];
    assign is_r = op == 7'b0110011;
    assign is_i = op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111;
    assign is_s = op == 7'b0100011;
    assign is_b = op == 7'b1100011;
    assign is_u = op == 7'b0110111 || op == 7'b0010111;
    assign is_j = op == 7'b1101111;
    assign valid = instrValid && (is_r || is_i || is_s || is_b || is_u || is_j);

    assign d_rs1 = valid && (is_r || is_i || is_s || is_b) ? instr[19:15] : 5'd0;
    assign d_rs2 = valid && (is_r || is_s || is_b) ? instr[24:20] : 5'd0;
    assign d_rd  = valid && (is_r || is_i || is_u || is_j) ? instr[11:7] : 5'd0;
    assign d_imm = is_i ? {{20{instr[31]}}, instr[31:20]} :
                   is_s ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
                   is_b ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
                   is_u ? {instr[31:12], 12'b0} :
                   is_j ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
                   32'd0;

    // Unused source fields decode to 0 and the issued rd is non-zero, so they never match.
    assign stall = state == RUN && opcode == 7'b0000011 && regWriteNum != 5'd0 &&
                   (d_rs1 == regWriteNum || d_rs2 == regWriteNum);

    assign dec = valid && !pcWriteEnable && (state == STALL || (state == RUN && !stall));

    // In FLUSH the counter holds the bubbles still to issue after this edge.
    assign next_state = pcWriteEnable ? (FLUSH_CYCLES == 1 ? RUN : FLUSH) :
                        state == RUN ? (stall ? STALL : RUN) :
                        state == FLUSH && cnt > CW'(1) ? FLUSH : RUN;
    assign next_cnt = pcWriteEnable ? CW'(FLUSH_CYCLES - 1) :
                      state == FLUSH && cnt != '0 ? cnt - CW'(1) : cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            cnt         <= '0;
            hazard      <= 1'b0;
            flush       <= 1'b0;
            PC          <= '0;
            opcode      <= '0;
            func3       <= '0;
            func7       <= '0;
            regNum0     <= '0;
            regNum1     <= '0;
            regWriteNum <= '0;
            imm         <= '0;
        end else begin
            state       <= next_state;
            cnt         <= next_cnt;
            hazard      <= !pcWriteEnable && state == RUN && stall;
            flush       <= pcWriteEnable || state == FLUSH;
            PC          <= dec ? instrPC : 32'd0;
            opcode      <= dec ? op : 7'd0;
            func3       <= dec ? instr[14:12] : 3'd0;
            func7       <= dec ? instr[31:25] : 7'd0;
            regNum0     <= dec ? d_rs1 : 5'd0;
            regNum1     <= dec ? d_rs2 : 5'd0;
            regWriteNum <= dec ? d_rd : 5'd0;
            imm         <= dec ? d_imm : 32'd0;
        end
    end
endmodule
